// File: rtl/fwu_frame_parser.sv
// Firmware-update frame parser: CMD(1) LEN(2,LE) PAYLOAD(LEN) [CRC16(2,LE)] from the SLIP receive stage.
// Define FWU_PARSER_CRC_EN to carry and check the CRC-16/CCITT-FALSE trailer.
module fwu_frame_parser #(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_frame_start,
  input  logic        in_frame_end,
  input  logic        in_frame_error,
  output logic        hdr_valid,
  output logic [7:0]  cmd,
  output logic [15:0] len,
  output logic [7:0]  pld_data,
  output logic        pld_valid,
  input  logic        pld_ready,
  output logic        pld_last,
  output logic        done,
  output logic [2:0]  status
);
  localparam int unsigned LW = 16;
  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_CRC   = 3'd1;
  localparam logic [2:0] ST_SHORT = 3'd2;
  localparam logic [2:0] ST_LONG  = 3'd3;
  localparam logic [2:0] ST_LEN   = 3'd4;
  localparam logic [2:0] ST_SLIP  = 3'd5;

  typedef enum logic [3:0] {
    S_HUNT, S_CMD, S_LEN0, S_LEN1, S_PAYLOAD, S_CRC0, S_CRC1, S_TAIL, S_DISCARD
  } state_t;

`ifdef FWU_PARSER_CRC_EN
  localparam state_t AFTER_PLD = S_CRC0;
`else
  localparam state_t AFTER_PLD = S_TAIL;
`endif

  state_t          state, state_n, eff_state;
  logic [7:0]      cmd_buf, cmd_buf_n, len_lo, len_lo_n, cmd_n;
  logic [LW-1:0]   len_n, idx, idx_n, new_len;
  logic            hdr_valid_n, done_n, restart, hs, last_beat, crc_ok;
  logic [2:0]      status_n, err_code, err_code_n;

`ifdef FWU_PARSER_CRC_EN
  logic [15:0] crc, crc_n, crc_base, rx_crc, rx_crc_n;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  assign new_len   = {in_data, len_lo};
  assign last_beat = (idx == len - LW'(1));

  // Markers are resolved first; the byte of the same cycle is handled in the resulting state.
  always_comb begin
    state_n     = state;
    eff_state   = state;
    restart     = 1'b0;
    done_n      = 1'b0;
    status_n    = status;
    err_code_n  = err_code;
    hdr_valid_n = 1'b0;
    cmd_n       = cmd;
    len_n       = len;
    cmd_buf_n   = cmd_buf;
    len_lo_n    = len_lo;
    idx_n       = idx;
    crc_ok      = 1'b1;
`ifdef FWU_PARSER_CRC_EN
    crc_ok      = (crc == rx_crc);
`endif

    if (in_frame_error && state != S_HUNT) begin
      done_n    = 1'b1;
      status_n  = ST_SLIP;
      eff_state = S_HUNT;
    end else if (in_frame_end) begin
      restart   = 1'b1;
      eff_state = S_CMD;
      case (state)
        S_HUNT, S_CMD: ;
        S_TAIL:    begin done_n = 1'b1; status_n = crc_ok ? ST_OK : ST_CRC; end
        S_DISCARD: begin done_n = 1'b1; status_n = err_code; end
        default:   begin done_n = 1'b1; status_n = ST_SHORT; end
      endcase
    end else if (in_frame_start) begin
      restart   = 1'b1;
      eff_state = S_CMD;
      if (state != S_HUNT && state != S_CMD) begin
        done_n   = 1'b1;
        status_n = ST_SHORT;
      end
    end
    state_n = eff_state;

    in_ready  = 1'b1;
    pld_valid = 1'b0;
    pld_last  = 1'b0;
    pld_data  = in_data;
    if (eff_state == S_PAYLOAD) begin
      in_ready  = pld_ready;
      pld_valid = in_valid;
      pld_last  = last_beat;
    end
    hs = in_valid && in_ready;

`ifdef FWU_PARSER_CRC_EN
    crc_base = restart ? 16'hFFFF : crc;
    crc_n    = crc_base;
    rx_crc_n = rx_crc;
    if (hs && (eff_state == S_CMD || eff_state == S_LEN0 || eff_state == S_LEN1 ||
               eff_state == S_PAYLOAD))
      crc_n = crc16_byte(crc_base, in_data);
`endif

    if (hs) begin
      case (eff_state)
        S_CMD:  begin cmd_buf_n = in_data; state_n = S_LEN0; end
        S_LEN0: begin len_lo_n = in_data; state_n = S_LEN1; end
        S_LEN1: begin
          if (new_len > LW'(MAX_LEN)) begin
            err_code_n = ST_LEN;
            state_n    = S_DISCARD;
          end else begin
            hdr_valid_n = 1'b1;
            cmd_n       = cmd_buf;
            len_n       = new_len;
            idx_n       = '0;
            state_n     = (new_len == '0) ? AFTER_PLD : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          idx_n = idx + LW'(1);
          if (last_beat) state_n = AFTER_PLD;
        end
        S_CRC0: begin
`ifdef FWU_PARSER_CRC_EN
          rx_crc_n[7:0] = in_data;
`endif
          state_n = S_CRC1;
        end
        S_CRC1: begin
`ifdef FWU_PARSER_CRC_EN
          rx_crc_n[15:8] = in_data;
`endif
          state_n = S_TAIL;
        end
        S_TAIL: begin err_code_n = ST_LONG; state_n = S_DISCARD; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      cmd       <= 8'h00;
      len       <= 16'h0000;
      hdr_valid <= 1'b0;
      done      <= 1'b0;
      status    <= ST_OK;
      cmd_buf   <= 8'h00;
      len_lo    <= 8'h00;
      idx       <= '0;
      err_code  <= ST_OK;
    end else begin
      state     <= state_n;
      cmd       <= cmd_n;
      len       <= len_n;
      hdr_valid <= hdr_valid_n;
      done      <= done_n;
      status    <= status_n;
      cmd_buf   <= cmd_buf_n;
      len_lo    <= len_lo_n;
      idx       <= idx_n;
      err_code  <= err_code_n;
    end
  end

`ifdef FWU_PARSER_CRC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc    <= 16'hFFFF;
      rx_crc <= 16'h0000;
    end else begin
      crc    <= crc_n;
      rx_crc <= rx_crc_n;
    end
  end
`endif

endmodule

// File: tb/tb_fwu_frame_parser.sv
// Directed, table-driven bench for fwu_frame_parser (tracks FWU_PARSER_CRC_EN like the design).
module tb_fwu_frame_parser;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, in_frame_start, in_frame_end, in_frame_error;
  logic        hdr_valid, pld_valid, pld_ready, pld_last, done;
  logic [7:0]  cmd, pld_data;
  logic [15:0] len;
  logic [2:0]  status;

  fwu_frame_parser #(.MAX_LEN(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_frame_start(in_frame_start), .in_frame_end(in_frame_end), .in_frame_error(in_frame_error),
    .hdr_valid(hdr_valid), .cmd(cmd), .len(len),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_last(pld_last),
    .done(done), .status(status)
  );

  always #5 clk = ~clk;

`ifdef FWU_PARSER_CRC_EN
  localparam logic [2:0] BAD_CRC_CODE = 3'd1;
`else
  localparam logic [2:0] BAD_CRC_CODE = 3'd0;
`endif

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    string       nm;
    logic        v;
    logic [7:0]  d;
    logic        st, en, er, pr;
    logic        e_rdy, e_pv, e_pl, e_hdr, e_done;
    logic [2:0]  e_status;
    logic [7:0]  e_cmd;
    logic [15:0] e_len;
  } vec_t;

  vec_t        vq[$];
  int          errors = 0;
  int          checks = 0;
  logic [2:0]  hold = 3'd0;
  logic [7:0]  hc = 8'h00;
  logic [15:0] hl = 16'h0000;
  logic [15:0] last_crc;

  function automatic logic [15:0] crc16(input byte_q_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push(input string nm, input logic v, input logic [7:0] d,
                      input logic st, input logic en, input logic er, input logic pr,
                      input logic rdy, input logic pv, input logic pl,
                      input logic hdr, input logic dn);
    vec_t x;
    x.nm = nm; x.v = v; x.d = d; x.st = st; x.en = en; x.er = er; x.pr = pr;
    x.e_rdy = rdy; x.e_pv = pv; x.e_pl = pl; x.e_hdr = hdr; x.e_done = dn;
    x.e_status = hold; x.e_cmd = hc; x.e_len = hl;
    vq.push_back(x);
  endtask

  task automatic hb(input string nm, input logic [7:0] d);
    push(nm, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hdr(input string nm, input logic [7:0] d, input logic [7:0] c, input logic [15:0] l);
    hc = c; hl = l;
    push(nm, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pb(input string nm, input logic [7:0] d, input logic pr, input logic last);
    push(nm, 1'b1, d, 1'b0, 1'b0, 1'b0, pr, pr, 1'b1, last, 1'b0, 1'b0);
  endtask

  task automatic mk(input string nm, input logic st, input logic en, input logic er,
                    input logic dn, input logic [2:0] code);
    if (dn) hold = code;
    push(nm, 1'b0, 8'h00, st, en, er, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, dn);
  endtask

  task automatic trailer(input string nm, input byte_q_t q);
    last_crc = crc16(q);
`ifdef FWU_PARSER_CRC_EN
    hb({nm, "_crc0"}, last_crc[7:0]);
    hb({nm, "_crc1"}, last_crc[15:8]);
`endif
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic st, input logic en,
                       input logic er, input logic pr);
    in_valid = v; in_data = d; in_frame_start = st; in_frame_end = en;
    in_frame_error = er; pld_ready = pr;
  endtask

  initial begin
    byte_q_t q;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.hdr_valid", 16'(hdr_valid), 16'h0);
    chk("reset.done", 16'(done), 16'h0);
    chk("reset.status", 16'(status), 16'h0);
    chk("reset.cmd", 16'(cmd), 16'h0);
    chk("reset.len", len, 16'h0);
    chk("reset.pld_last", 16'(pld_last), 16'h0);
    chk("reset.in_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // HUNT, then empty-payload frame 01/0000 with trailer AC FB
    mk("idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    hb("hunt_drop", 8'h55);
    mk("f1_start", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    hb("f1_cmd", 8'h01);
    hb("f1_len0", 8'h00);
    hdr("f1_len1", 8'h00, 8'h01, 16'h0000);
`ifdef FWU_PARSER_CRC_EN
    hb("f1_crc0", 8'hAC);
    hb("f1_crc1", 8'hFB);
`endif
    mk("f1_end", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);

    // 4-byte payload with pld_ready toggling
    hb("f2_cmd", 8'h10);
    hb("f2_len0", 8'h04);
    hdr("f2_len1", 8'h00, 8'h10, 16'h0004);
    pb("f2_de", 8'hDE, 1'b1, 1'b0);
    pb("f2_ad_stall", 8'hAD, 1'b0, 1'b0);
    pb("f2_ad", 8'hAD, 1'b1, 1'b0);
    pb("f2_be_stall", 8'hBE, 1'b0, 1'b0);
    pb("f2_be", 8'hBE, 1'b1, 1'b0);
    pb("f2_ef_stall", 8'hEF, 1'b0, 1'b1);
    pb("f2_ef", 8'hEF, 1'b1, 1'b1);
    q = {8'h10, 8'h04, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    trailer("f2", q);
    mk("f2_end", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);

    // Same frame, last payload byte corrupted
    hb("f3_cmd", 8'h10);
    hb("f3_len0", 8'h04);
    hdr("f3_len1", 8'h00, 8'h10, 16'h0004);
    pb("f3_de", 8'hDE, 1'b1, 1'b0);
    pb("f3_ad", 8'hAD, 1'b1, 1'b0);
    pb("f3_be", 8'hBE, 1'b1, 1'b0);
    pb("f3_ee", 8'hEE, 1'b1, 1'b1);
    trailer("f3", q);
    mk("f3_end", 1'b0, 1'b1, 1'b0, 1'b1, BAD_CRC_CODE);

    // Frame cut after LEN1, then a good 1-byte frame
    hb("f4_cmd", 8'h22);
    hb("f4_len0", 8'h03);
    hdr("f4_len1", 8'h00, 8'h22, 16'h0003);
    mk("f4_end_short", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);
    hb("f5_cmd", 8'h05);
    hb("f5_len0", 8'h01);
    hdr("f5_len1", 8'h00, 8'h05, 16'h0001);
    pb("f5_5a", 8'h5A, 1'b1, 1'b1);
    q = {8'h05, 8'h01, 8'h00, 8'h5A};
    trailer("f5", q);
    mk("f5_end", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);

    // LEN = 0x0401 exceeds MAX_LEN; then an empty END is ignored
    hb("f6_cmd", 8'h33);
    hb("f6_len0", 8'h01);
    hb("f6_len1_big", 8'h04);
    hb("f6_disc0", 8'h11);
    hb("f6_disc1", 8'h22);
    mk("f6_end_len", 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    mk("empty_end", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    // Extra byte after the trailer
    hb("f7_cmd", 8'h01);
    hb("f7_len0", 8'h00);
    hdr("f7_len1", 8'h00, 8'h01, 16'h0000);
    q = {8'h01, 8'h00, 8'h00};
    trailer("f7", q);
    hb("f7_extra", 8'h99);
    mk("f7_end_long", 1'b0, 1'b1, 1'b0, 1'b1, 3'd3);

    // SLIP error mid-payload, HUNT ignores bytes and errors
    hb("f8_cmd", 8'h44);
    hb("f8_len0", 8'h02);
    hdr("f8_len1", 8'h00, 8'h44, 16'h0002);
    pb("f8_p0", 8'h01, 1'b1, 1'b0);
    mk("f8_err", 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    hb("hunt_byte", 8'h77);
    mk("hunt_err", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

    // Start pulse coinciding with the CMD byte
    push("f9_start_cmd", 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hb("f9_len0", 8'h00);
    hdr("f9_len1", 8'h00, 8'h01, 16'h0000);
    trailer("f9", q);
    mk("f9_end", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);

    // Start pulse mid-frame closes it as SHORT
    hb("f10_cmd", 8'h66);
    mk("f10_restart", 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].v, vq[i].d, vq[i].st, vq[i].en, vq[i].er, vq[i].pr);
      #1;
      chk({vq[i].nm, ".in_ready"}, 16'(in_ready), 16'(vq[i].e_rdy));
      chk({vq[i].nm, ".pld_valid"}, 16'(pld_valid), 16'(vq[i].e_pv));
      chk({vq[i].nm, ".pld_last"}, 16'(pld_last), 16'(vq[i].e_pl));
      if (vq[i].e_pv) chk({vq[i].nm, ".pld_data"}, 16'(pld_data), 16'(vq[i].d));
      @(posedge clk);
      #1;
      chk({vq[i].nm, ".hdr_valid"}, 16'(hdr_valid), 16'(vq[i].e_hdr));
      chk({vq[i].nm, ".done"}, 16'(done), 16'(vq[i].e_done));
      chk({vq[i].nm, ".status"}, 16'(status), 16'(vq[i].e_status));
      chk({vq[i].nm, ".cmd"}, 16'(cmd), 16'(vq[i].e_cmd));
      chk({vq[i].nm, ".len"}, len, vq[i].e_len);
    end

    // Reset asserted mid-payload aborts silently
    @(negedge clk); drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_seq.pld_valid_before", 16'(pld_valid), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_seq.pld_valid", 16'(pld_valid), 16'h0);
    chk("rst_seq.in_ready", 16'(in_ready), 16'h1);
    chk("rst_seq.pld_last", 16'(pld_last), 16'h0);
    chk("rst_seq.hdr_valid", 16'(hdr_valid), 16'h0);
    chk("rst_seq.done", 16'(done), 16'h0);
    chk("rst_seq.status", 16'(status), 16'h0);
    chk("rst_seq.cmd", 16'(cmd), 16'h0);
    chk("rst_seq.len", len, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst_seq.no_done", 16'(done), 16'h0);
      chk("rst_seq.status_hold", 16'(status), 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
